// File: rtl/ps2_jump_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw pins, frames 11-bit words,
// and decodes make/break/extended sequences into a held jump-key level.
module ps2_jump_decoder #(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] JUMP_CODE      = 8'h29
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       jump_key,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          w_event;
  state_t        r_state, w_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_byte;
  logic          r_par_ok;
  logic [TW-1:0] r_to_cnt;
  logic          w_start_err, w_accept, w_stop_err, w_timeout;
  logic          r_ext, r_brk;
  logic          r_jump, r_valid, r_err;
  logic [7:0]    r_scan;

  // Two-flop synchronizers for both pins; idle bus level is high
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_sync != r_filt_clk) begin
      if (r_filt_cnt == FILT_LAST) begin
        r_filt_clk <= r_clk_sync;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end else begin
      r_filt_cnt <= '0;
    end
  end

  assign w_event = r_filt_clk && !r_clk_sync && (r_filt_cnt == FILT_LAST);

  // Frame FSM state register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frame FSM next-state logic
  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (w_event) begin
      case (r_state)
        S_IDLE:   w_next = r_dat_sync ? S_IDLE : S_DATA;
        S_DATA:   w_next = (r_bit_cnt == 3'd7) ? S_PARITY : S_DATA;
        S_PARITY: w_next = S_STOP;
        S_STOP:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end else begin
      w_next = r_state;
    end
  end

  // Frame FSM outputs: per-event outcome strobes and the inter-bit timeout
  always_comb begin
    w_start_err = 1'b0;
    w_accept    = 1'b0;
    w_stop_err  = 1'b0;
    w_timeout   = (r_state != S_IDLE) && !w_event && (r_to_cnt == TO_LAST);
    case (r_state)
      S_IDLE: w_start_err = w_event && r_dat_sync;
      S_STOP: begin
        w_accept   = w_event && r_dat_sync && r_par_ok;
        w_stop_err = w_event && !(r_dat_sync && r_par_ok);
      end
      default: begin
        w_start_err = 1'b0;
        w_accept    = 1'b0;
        w_stop_err  = 1'b0;
      end
    endcase
  end

  // Shift register, bit counter, parity result and timeout counter
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
      r_byte    <= 8'h00;
      r_par_ok  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE || w_event) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
      if (w_event) begin
        case (r_state)
          S_IDLE: r_bit_cnt <= 3'd0;
          S_DATA: begin
            r_byte    <= {r_dat_sync, r_byte[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_par_ok <= ^{r_byte, r_dat_sync};
          default:  r_bit_cnt <= r_bit_cnt;
        endcase
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end
    end
  end

  // Registered outputs and make/break/extended decode of accepted bytes
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_scan  <= 8'h00;
      r_jump  <= 1'b0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_err   <= w_start_err | w_stop_err | w_timeout;
      if (w_accept) begin
        r_scan <= r_byte;
        if (r_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          if (!r_ext && (r_byte == JUMP_CODE)) begin
            r_jump <= ~r_brk;
          end else begin
            r_jump <= r_jump;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end else if (w_stop_err || w_timeout) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else begin
        r_ext <= r_ext;
        r_brk <= r_brk;
      end
    end
  end

  assign jump_key   = r_jump;
  assign scan_code  = r_scan;
  assign code_valid = r_valid;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_ps2_jump_decoder.sv
// Directed bench for ps2_jump_decoder: sends PS/2 frames and checks pulses and the
// jump-key level every cycle against a queue-based model of the key protocol.
module tb_ps2_jump_decoder;

  localparam int ERR = 256;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       jump_key;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  bit exp_jump = 1'b0;
  bit exp_ext = 1'b0;
  bit exp_brk = 1'b0;
  bit prev_pulse = 1'b0;
  int cv_cnt = 0;
  int err_cnt = 0;

  ps2_jump_decoder #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(2000),
    .JUMP_CODE     (8'h29)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .jump_key  (jump_key),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 sysclk = ~sysclk;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Key-protocol model: prefixes arm flags, the next plain byte resolves them
  function automatic void model_apply(int b);
    if (b == 32'hE0) exp_ext = 1'b1;
    else if (b == 32'hF0) exp_brk = 1'b1;
    else begin
      if (!exp_ext && b == 32'h29) exp_jump = !exp_brk;
      exp_ext = 1'b0;
      exp_brk = 1'b0;
    end
  endfunction

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge sysclk);
      if (reset) begin
        exp_jump = 1'b0;
        exp_ext = 1'b0;
        exp_brk = 1'b0;
        exp_q.delete();
        prev_pulse = 1'b0;
      end else begin
        if (code_valid || frame_err) begin
          chk("exclusive", int'(code_valid & frame_err), 0);
          chk("pulse_width", int'(prev_pulse), 0);
        end
        if (code_valid) begin
          cv_cnt++;
          chk("valid_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            chk("scan_code", int'(scan_code), exp_q[0]);
            model_apply(exp_q.pop_front());
          end
        end
        if (frame_err) begin
          err_cnt++;
          chk("err_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            chk("err_kind", exp_q.pop_front(), ERR);
            exp_ext = 1'b0;
            exp_brk = 1'b0;
          end
        end
        chk("jump_key", int'(jump_key), int'(exp_jump));
        prev_pulse = code_valid | frame_err;
      end
    end
  end

  // Send the first nbits of a frame (200-cycle bit period), then idle
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit push);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (push) exp_q.push_back(bad_par ? ERR : int'(b));
    for (int i = 0; i < nbits; i++) begin
      @(negedge sysclk);
      ps2_data = f[i];
      repeat (100) @(negedge sysclk);
      ps2_clk = 1'b0;
      repeat (100) @(negedge sysclk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (200) @(negedge sysclk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b1);
  endtask

  task automatic drain();
    #2;
    chk("drain_queue", exp_q.size(), 0);
    exp_q.delete();
  endtask

  int cv0, er0;

  initial begin
    repeat (3) @(negedge sysclk);
    #1;
    chk("rst_jump", int'(jump_key), 0);
    chk("rst_scan", int'(scan_code), 8'h00);
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_err", int'(frame_err), 0);
    @(negedge sysclk);
    reset = 1'b0;
    repeat (20) @(negedge sysclk);

    // 1: press then release
    cv0 = cv_cnt;
    send(8'h29); drain();
    chk("t1_pulses", cv_cnt - cv0, 1);
    chk("t1_scan", int'(scan_code), 8'h29);
    chk("t1_jump", int'(jump_key), 1);
    cv0 = cv_cnt;
    send(8'hF0); send(8'h29); drain();
    chk("t1_rel_pulses", cv_cnt - cv0, 2);
    chk("t1_rel_jump", int'(jump_key), 0);

    // 2: typematic repeats
    cv0 = cv_cnt;
    send(8'h29); send(8'h29); send(8'h29); drain();
    chk("t2_pulses", cv_cnt - cv0, 3);
    chk("t2_jump", int'(jump_key), 1);
    send(8'hF0); send(8'h29); drain();
    chk("t2_rel_jump", int'(jump_key), 0);

    // 3: parity error then good frame
    cv0 = cv_cnt; er0 = err_cnt;
    send_frame(8'h29, 1'b1, 11, 1'b1); drain();
    chk("t3_errs", err_cnt - er0, 1);
    chk("t3_pulses", cv_cnt - cv0, 0);
    chk("t3_jump_hold", int'(jump_key), 0);
    send(8'h29); drain();
    chk("t3_jump", int'(jump_key), 1);
    send(8'hF0); send(8'h29); drain();

    // 4: extended code equal to jump code, then another key
    cv0 = cv_cnt;
    send(8'hE0); send(8'h29); drain();
    chk("t4_pulses", cv_cnt - cv0, 2);
    chk("t4_jump", int'(jump_key), 0);
    send(8'h1C); drain();
    chk("t4_scan", int'(scan_code), 8'h1C);
    chk("t4_jump2", int'(jump_key), 0);

    // 5: truncated frame times out
    er0 = err_cnt;
    send_frame(8'h29, 1'b0, 5, 1'b0);
    exp_q.push_back(ERR);
    repeat (2100) @(negedge sysclk);
    drain();
    chk("t5_errs", err_cnt - er0, 1);
    send(8'h29); drain();
    chk("t5_jump", int'(jump_key), 1);

    // 6: reset mid-frame, then a short clock glitch
    send_frame(8'h29, 1'b0, 5, 1'b0);
    @(negedge sysclk);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_jump", int'(jump_key), 0);
    chk("t6_rst_scan", int'(scan_code), 8'h00);
    chk("t6_rst_valid", int'(code_valid), 0);
    chk("t6_rst_err", int'(frame_err), 0);
    repeat (3) @(negedge sysclk);
    #3 reset = 1'b0;
    repeat (10) @(negedge sysclk);
    cv0 = cv_cnt; er0 = err_cnt;
    ps2_clk = 1'b0;
    repeat (2) @(negedge sysclk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge sysclk);
    #2;
    chk("t6_glitch_valid", cv_cnt - cv0, 0);
    chk("t6_glitch_err", err_cnt - er0, 0);
    send(8'h29); drain();
    chk("t6_jump", int'(jump_key), 1);
    chk("t6_scan", int'(scan_code), 8'h29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
